// File: rtl/xform_pkg.sv
// Shared constants and FSM state type for the transform frame packer.
package xform_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LANES      = 4;
    localparam int NUM_ROWS   = 3;
    localparam int NUM_COEF   = NUM_ROWS * LANES;

    localparam logic [15:0] W_ONE = 16'd1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PTS
    } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register; holds data and last stable while stalled.
module axis_out_reg #(
    parameter int WIDTH = 64
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // A new beat may enter when the slot is empty or is being drained this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
            last_q  <= in_last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/xform_frame_packer.sv
// Builds transform frames: three matrix-row header beats followed by {1, z, y, x} point beats.
module xform_frame_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_wr_en,
    input  logic [3:0]                  cfg_addr,
    input  logic [DATA_WIDTH-1:0]       cfg_wdata,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        num_points,
    input  logic [3*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        done,
    output logic                        len_err
);

    import xform_pkg::*;

    localparam int BEAT_W = LANES * DATA_WIDTH;

    state_t                                 state_q;
    logic [1:0]                             row_q;
    logic [CNT_WIDTH-1:0]                   cnt_q;
    logic                                   lastLoaded_q;
    logic                                   busy_q;
    logic                                   done_q;
    logic                                   lenErr_q;
    logic [NUM_COEF-1:0][DATA_WIDTH-1:0]    coef_q;
    logic [NUM_COEF-1:0][DATA_WIDTH-1:0]    coef_d;

    logic              outReady;
    logic              startAccept;
    logic              outAccept;
    logic              inAccept;
    logic              cntIsOne;
    logic [1:0]        hdrRow;
    logic [BEAT_W-1:0] hdrBeat;
    logic              loadValid;
    logic              loadLast;
    logic [BEAT_W-1:0] loadData;

    // Pending write is folded in so a start in the same cycle sees the new coefficient.
    always_comb begin
        coef_d = coef_q;
        if (state_q == IDLE && cfg_wr_en && cfg_addr < 4'(NUM_COEF)) begin
            coef_d[cfg_addr] = cfg_wdata;
        end
    end

    assign hdrRow  = (state_q == IDLE) ? 2'd0 : row_q + 2'd1;
    assign hdrBeat = coef_d[{hdrRow, 2'b00} +: LANES];

    assign startAccept   = (state_q == IDLE) && start && (num_points != '0);
    assign outAccept     = m_axis_tvalid && m_axis_tready;
    assign s_axis_tready = (state_q == PTS) && !lastLoaded_q && outReady;
    assign inAccept      = s_axis_tvalid && s_axis_tready;
    assign cntIsOne      = (cnt_q == CNT_WIDTH'(1));

    always_comb begin
        loadValid = 1'b0;
        loadLast  = 1'b0;
        loadData  = '0;
        case (state_q)
            IDLE: begin
                if (startAccept) begin
                    loadValid = 1'b1;
                    loadData  = hdrBeat;
                end
            end
            HDR: begin
                if (outAccept && row_q != 2'd2) begin
                    loadValid = 1'b1;
                    loadData  = hdrBeat;
                end
            end
            PTS: begin
                if (inAccept) begin
                    loadValid = 1'b1;
                    loadData  = {DATA_WIDTH'(W_ONE), s_axis_tdata};
                    loadLast  = cntIsOne || s_axis_tlast;
                end
            end
            default: begin
            end
        endcase
    end

    // Frame sequencing; lastLoaded_q stops point intake once the tlast beat is queued.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            row_q        <= 2'd0;
            cnt_q        <= '0;
            lastLoaded_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            lenErr_q     <= 1'b0;
            coef_q       <= '0;
        end else begin
            coef_q   <= coef_d;
            done_q   <= 1'b0;
            lenErr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startAccept) begin
                        state_q      <= HDR;
                        row_q        <= 2'd0;
                        cnt_q        <= num_points;
                        lastLoaded_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end
                HDR: begin
                    if (outAccept) begin
                        if (row_q == 2'd2) begin
                            state_q <= PTS;
                        end else begin
                            row_q <= row_q + 2'd1;
                        end
                    end
                end
                PTS: begin
                    if (inAccept) begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                        if (cntIsOne || s_axis_tlast) begin
                            lastLoaded_q <= 1'b1;
                        end
                        if (cntIsOne != s_axis_tlast) begin
                            lenErr_q <= 1'b1;
                        end
                    end
                    if (outAccept && m_axis_tlast) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign len_err = lenErr_q;

    axis_out_reg #(
        .WIDTH (BEAT_W)
    ) u_out_reg (
        .aclk        (aclk),
        .areset      (areset),
        .in_valid_i  (loadValid),
        .in_data_i   (loadData),
        .in_last_i   (loadLast),
        .in_ready_o  (outReady),
        .out_valid_o (m_axis_tvalid),
        .out_data_o  (m_axis_tdata),
        .out_last_o  (m_axis_tlast),
        .out_ready_i (m_axis_tready)
    );

endmodule

// File: tb/tb_xform_frame_packer.sv
// Directed self-checking bench for xform_frame_packer using hand-computed frame beats.
module tb_xform_frame_packer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        cfg_wr_en;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        start;
    logic [15:0] num_points;
    logic [47:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic        len_err;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [15:0] COEFS [12] = '{
        16'd41, 16'd0,  16'd0,  16'hB000,
        16'd0,  16'd41, 16'd0,  16'hC000,
        16'd0,  16'd0,  16'd41, 16'hBB33
    };

    localparam logic [63:0] EXP_HDR [3] = '{
        64'hb000_0000_0000_0029,
        64'hc000_0000_0029_0000,
        64'hbb33_0029_0000_0000
    };

    localparam logic [15:0] PX [5] = '{16'd300, 16'd600, 16'd800, 16'd25, 16'd25};
    localparam logic [15:0] PY [5] = '{16'd800, 16'd0,   16'd500, 16'd25, 16'd25};
    localparam logic [15:0] PZ [5] = '{16'd500, 16'd400, 16'd400, 16'd25, 16'd75};

    localparam logic [63:0] EXP_PTS [5] = '{
        64'h0001_01f4_0320_012c,
        64'h0001_0190_0000_0258,
        64'h0001_0190_01f4_0320,
        64'h0001_0019_0019_0019,
        64'h0001_004b_0019_0019
    };

    always #5 aclk = ~aclk;

    xform_frame_packer dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .start         (start),
        .num_points    (num_points),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .len_err       (len_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput($sformatf("%s:tvalid", tag), 64'(m_axis_tvalid), 64'd0);
        checkOutput($sformatf("%s:tdata", tag),  m_axis_tdata,       64'd0);
        checkOutput($sformatf("%s:tlast", tag),  64'(m_axis_tlast),  64'd0);
        checkOutput($sformatf("%s:sready", tag), 64'(s_axis_tready), 64'd0);
        checkOutput($sformatf("%s:busy", tag),   64'(busy),          64'd0);
        checkOutput($sformatf("%s:done", tag),   64'(done),          64'd0);
        checkOutput($sformatf("%s:lenerr", tag), 64'(len_err),       64'd0);
    endtask

    task automatic loadCoefs();
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            cfg_wr_en = 1'b1;
            cfg_addr  = 4'(i);
            cfg_wdata = COEFS[i];
        end
        @(negedge aclk);
        cfg_wr_en = 1'b0;
    endtask

    // Runs one frame cycle by cycle: inputs change on the falling edge, outputs are sampled 1ns later.
    task automatic applyStimulus(input string name, input int numPts, input int nFeed, input int tlastIdx,
                                 input bit toggleReady, input bit cfgPoke, input int abortAt,
                                 input int expBeats, input int expLenErr, input bit zeroHdr);
        logic [63:0] beatData [$];
        logic        beatLast [$];
        int          idx = 0;
        int          doneCnt = 0;
        int          errCnt = 0;
        int          stallViol = 0;
        int          sStall = 0;
        int          tail = -1;
        int          lastCnt = 0;
        int          lastPos = -1;
        logic        prevStall = 1'b0;
        logic [63:0] prevData = '0;
        logic        prevLast = 1'b0;
        logic [63:0] expBeat;

        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge aclk);
            start      = (cyc == 0);
            num_points = 16'(numPts);
            cfg_wr_en  = cfgPoke && (cyc == 4);
            cfg_addr   = 4'd0;
            cfg_wdata  = 16'd7;
            if (toggleReady) begin
                m_axis_tready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
            end else begin
                m_axis_tready = 1'b1;
            end
            if (idx < nFeed) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {PZ[idx], PY[idx], PX[idx]};
                s_axis_tlast  = (idx == tlastIdx);
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = '0;
                s_axis_tlast  = 1'b0;
            end
            if (cyc == abortAt) begin
                #1;
                checkOutput($sformatf("%s:busyPreReset", name),  64'(busy),          64'd1);
                checkOutput($sformatf("%s:validPreReset", name), 64'(m_axis_tvalid), 64'd1);
                areset = 1'b1;
                #1;
                checkAllZero($sformatf("%s:midReset", name));
                @(negedge aclk);
                areset        = 1'b0;
                start         = 1'b0;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                cfg_wr_en     = 1'b0;
                return;
            end
            #1;
            if (cyc == 1) begin
                checkOutput($sformatf("%s:hdrLatency", name), 64'(m_axis_tvalid), 64'd1);
                checkOutput($sformatf("%s:busyHigh", name),   64'(busy),          64'd1);
            end
            if (m_axis_tvalid && prevStall) begin
                if (m_axis_tdata !== prevData || m_axis_tlast !== prevLast) stallViol++;
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevData  = m_axis_tdata;
            prevLast  = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                beatData.push_back(m_axis_tdata);
                beatLast.push_back(m_axis_tlast);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (m_axis_tvalid && !m_axis_tready) sStall++;
                idx++;
            end
            if (len_err) errCnt++;
            if (done) begin
                doneCnt++;
                if (tail < 0) begin
                    tail = 3;
                    checkOutput($sformatf("%s:busyAtDone", name), 64'(busy), 64'd0);
                end
            end
            if (tail >= 0) begin
                if (tail == 0) break;
                tail--;
            end
        end
        start         = 1'b0;
        cfg_wr_en     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        if (tail < 0) checkOutput($sformatf("%s:timeoutNoDone", name), 64'd1, 64'd0);
        checkOutput($sformatf("%s:beatCount", name), 64'(beatData.size()), 64'(expBeats));
        for (int i = 0; i < expBeats && i < beatData.size(); i++) begin
            if (i < 3) expBeat = zeroHdr ? 64'd0 : EXP_HDR[i];
            else       expBeat = EXP_PTS[i-3];
            checkOutput($sformatf("%s:beat%0d", name, i), beatData[i], expBeat);
        end
        foreach (beatLast[i]) begin
            if (beatLast[i]) begin
                lastCnt++;
                if (lastPos < 0) lastPos = i;
            end
        end
        checkOutput($sformatf("%s:tlastCount", name), 64'(lastCnt), 64'd1);
        checkOutput($sformatf("%s:tlastPos", name),   64'(lastPos), 64'(expBeats - 1));
        checkOutput($sformatf("%s:doneCount", name),  64'(doneCnt), 64'd1);
        checkOutput($sformatf("%s:lenErrCount", name), 64'(errCnt), 64'(expLenErr));
        checkOutput($sformatf("%s:stallStable", name), 64'(stallViol), 64'd0);
        checkOutput($sformatf("%s:noInputDuringStall", name), 64'(sStall), 64'd0);
    endtask

    initial begin
        areset        = 1'b1;
        cfg_wr_en     = 1'b0;
        cfg_addr      = '0;
        cfg_wdata     = '0;
        start         = 1'b0;
        num_points    = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(negedge aclk);
        #1;
        checkAllZero("reset");
        @(negedge aclk);
        areset = 1'b0;

        loadCoefs();
        applyStimulus("basic",    5, 5, 4,  1'b0, 1'b0, -1, 8, 0, 1'b0);
        applyStimulus("stalled",  5, 5, 4,  1'b1, 1'b0, -1, 8, 0, 1'b0);
        applyStimulus("early",    5, 3, 2,  1'b0, 1'b0, -1, 6, 1, 1'b0);
        applyStimulus("recover",  5, 5, 4,  1'b0, 1'b0, -1, 8, 0, 1'b0);
        applyStimulus("short",    2, 2, -1, 1'b0, 1'b0, -1, 5, 1, 1'b0);

        @(negedge aclk);
        start      = 1'b1;
        num_points = 16'd0;
        @(negedge aclk);
        start = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        checkOutput("zeroPts:busy",   64'(busy),          64'd0);
        checkOutput("zeroPts:tvalid", 64'(m_axis_tvalid), 64'd0);

        applyStimulus("busyWrite", 5, 5, 4, 1'b0, 1'b1, -1, 8, 0, 1'b0);
        applyStimulus("afterBusyWrite", 5, 5, 4, 1'b0, 1'b0, -1, 8, 0, 1'b0);

        applyStimulus("abort", 5, 5, 4, 1'b0, 1'b0, 7, 8, 0, 1'b0);
        applyStimulus("postResetZeroCoef", 5, 5, 4, 1'b0, 1'b0, -1, 8, 0, 1'b1);
        loadCoefs();
        applyStimulus("postResetReload", 5, 5, 4, 1'b0, 1'b0, -1, 8, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/xform_frame_packer.md
Name: xform_frame_packer

Overview:
- Builds the AXI-Stream frame consumed by the horner transform top: three 64-bit matrix-row header beats (3x4 Q16 matrix), then N point beats packed as {w=1, z, y, x}, with tlast on the last point beat.
- Sits directly upstream of the transform top's s00_axis port.
- Matrix coefficients are loaded through a simple register write port.
- Raw 3-lane points arrive on a slave AXIS port.

Parameters:
- DATA_WIDTH, 16, width of one coefficient/coordinate lane.
- LANES, 4, lanes per output beat; fixed at 4, since the frame format is 3 rows x 4 coefficients.
- CNT_WIDTH, 16, width of the point counter / num_points.

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  reset; asynchronous, active-high.
- cfg_wr_en  in  1  coefficient write strobe.
- cfg_addr  in  4  coefficient index 0..11; row r, lane l -> index r*4+l.
- cfg_wdata  in  DATA_WIDTH  coefficient value (Q16, two's complement).
- start  in  1  single-cycle frame start pulse.
- num_points  in  CNT_WIDTH  points in the frame; sampled on an accepted start.
- s_axis_tdata  in  3*DATA_WIDTH  point {z, y, x}, with x in the low bits.
- s_axis_tvalid  in  1  point valid.
- s_axis_tready  out  1  point accepted.
- s_axis_tlast  in  1  producer end-of-frame marker.
- m_axis_tdata  out  LANES*DATA_WIDTH  frame beat to the transform top.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last beat is accepted.
- len_err  out  1  one-cycle pulse on a length mismatch (see below).

Behaviour:
- Reset (async assert, released synchronously by design): all outputs go to 0 (m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, busy, done, len_err), all 12 coefficient registers go to 0, and the FSM returns to IDLE.
  - A reset mid-frame discards the frame with no partial tlast.
- Coefficient writes:
  - Written on cfg_wr_en when the FSM is in IDLE.
  - Ignored while busy.
  - cfg_addr values 12..15 are ignored.
- FSM states: IDLE, HDR, PTS.
  - IDLE -> HDR on start && num_points != 0. The count is latched and busy goes to 1 the next cycle.
  - start with num_points == 0 is ignored.
  - start while busy is ignored.
- HDR:
  - Emits rows 0, 1, 2 in order.
  - Row beat = {m[r*4+3], m[r*4+2], m[r*4+1], m[r*4+0]}, tlast = 0.
  - Header beat 0 is valid in the cycle after start is accepted.
  - Advances one row per accepted beat (m_axis_tvalid && m_axis_tready).
  - After row 2 is accepted -> PTS.
- PTS:
  - Output beat = {16'd1, z, y, x}.
  - tlast = 1 when the remaining count == 1, or when s_axis_tlast = 1 on the accepted input beat.
  - s_axis_tready = (state == PTS) && (!m_axis_tvalid || m_axis_tready): single output register, full throughput, no bubbles under continuous valid/ready.
  - Point latency is 1 cycle (input accepted -> m_axis_tvalid next cycle).
- Frame end, in PTS -> IDLE when the tlast beat is accepted downstream:
  - done pulses and busy drops in that same cycle.
  - The next frame's start is accepted from the following cycle.
- Length checks:
  - If s_axis_tlast = 1 before the count reaches 1, the frame ends early (that beat carries tlast) and len_err pulses.
  - If the count reaches 1 with s_axis_tlast = 0, tlast is still emitted and len_err pulses.
  - Matching tlast produces no error.
- Backpressure:
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid && !m_axis_tready.
  - No beats are dropped or duplicated.
- Simultaneous cfg write and start in IDLE: the write is applied, and the header uses the updated value, because header data is read from registers at beat-load time.

Decomposition:
- Shared package xform_pkg holds:
  - DATA_WIDTH, LANES, NUM_ROWS=3, NUM_COEF=12.
  - W_ONE = 16'd1.
  - FSM state enum {IDLE, HDR, PTS}.
- One natural sub-module, axis_out_reg: a single-entry AXIS output register with stall hold. The FSM, coefficient bank and counter stay in the top module.

Test Plan:
- Load coefs 41, 0, 0, -20480, 0, 41, 0, -16384, 0, 0, 41, -17613; start with num_points=5; ready held at 1; feed (300,800,500), (600,0,400), (800,500,400), (25,25,25), (25,25,75) with tlast on the 5th. Required outputs:
  - Header beats b000_0000_0000_0029, c000_0000_0029_0000, bb33_0029_0000_0000.
  - Point beats starting 0001_01f4_0320_012c, 0001_0190_0000_0258, …
  - tlast only on the 8th beat; done pulses once; len_err stays 0.
- Same frame with m_axis_tready toggled 1,0,0,1 repeating -> identical 8-beat sequence; tdata held stable during stalls; no s_axis handshake while the output is stalled.
- num_points=5 with s_axis_tlast on the 3rd point -> 6 beats, tlast on the 6th, len_err pulses once; a second start then yields a correct full frame.
- num_points=2 with no s_axis_tlast -> tlast on the 5th beat and len_err pulses. Also, start with num_points=0 -> busy stays 0 and no output.
- cfg write of index 0 = 7 while busy -> the next frame's header beat 0 still shows 0029. Assert areset mid-PTS -> all outputs 0 immediately; the next frame after release is complete and correct.
